mult_dot_acc: RTL and testbench

- Dot-product accumulator wrapped around the pipelined multiplier `mult_LP_V3`.
- Accepts operand pairs on a valid/ready stream and drives them straight into the multiplier.
- Tags each operand pair so the matching product is recognised when it comes out of the multiplier pipe, then accumulates products until the last-tagged element.
- Presents the sum on a valid/ready result port.

---
 rtl/mult_dot_acc.sv | 172 +++++++++++++++++
 tb/tb_mult_dot_acc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_dot_acc.sv
// mult_dot_acc: dot-product accumulator wrapped around the pipelined
// multiplier mult_LP_V3.
//
// Operand pairs arrive on a valid/ready stream. They go straight to the
// multiplier. A LAT-deep tag pipe follows each accepted pair, so the matching
// product is recognised when it leaves the multiplier. Products are summed
// until the product tagged "last" arrives. The sum, element count and overflow
// flag are then presented on a valid/ready result port. Only one vector is in
// flight at a time.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand stream handshake
//   in_a, in_b          unsigned operands
//   in_last             pair terminates the current vector
//   mul_a, mul_b        operands to the multiplier (combinational pass-through)
//   mul_p               product from the multiplier, LAT cycles later
//   out_valid/out_ready result handshake
//   out_sum             dot-product sum, wraps modulo 2^ACC_W
//   out_len             element count, saturating at 2^CNT_W-1
//   out_ovf             accumulator carried out during this vector
module mult_dot_acc #(
  parameter int W     = 8,
  parameter int LAT   = 10,
  parameter int G     = 4,
  parameter int CNT_W = 8,
  localparam int ACC_W = 2*W + G
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic               in_last,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic [2*W-1:0]     mul_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [CNT_W-1:0]   out_len,
  output logic               out_ovf
);

  typedef enum logic [1:0] {
    S_ACC   = 2'd0,
    S_FLUSH = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [LAT-1:0]     tag_vld_q, tag_vld_d;
  logic [LAT-1:0]     tag_last_q, tag_last_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_len_q, out_len_d;
  logic               out_ovf_q, out_ovf_d;

  logic               accept;
  logic               prod_vld;
  logic               prod_last;
  logic [ACC_W:0]     sum_ext;
  logic               carry;

  assign mul_a     = in_a;
  assign mul_b     = in_b;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_len   = out_len_q;
  assign out_ovf   = out_ovf_q;

  // Stage 0: accept, tag entry into the pipe tracking the multiplier
  always_comb begin
    accept     = in_valid && in_ready_q;
    tag_vld_d  = {tag_vld_q[LAT-2:0], accept};
    tag_last_d = {tag_last_q[LAT-2:0], accept && in_last};
  end

  // Stage LAT-1: tagged product leaves the multiplier and is accumulated
  always_comb begin
    prod_vld  = tag_vld_q[LAT-1];
    prod_last = tag_last_q[LAT-1];
    sum_ext   = {1'b0, acc_q} + (ACC_W+1)'(mul_p);
    carry     = sum_ext[ACC_W];

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_len_d   = out_len_q;
    out_ovf_d   = out_ovf_q;

    if (prod_vld) begin
      if (prod_last) begin
        // Final product: publish the totals and restart the accumulator
        // in the same edge.
        out_sum_d   = sum_ext[ACC_W-1:0];
        out_len_d   = sat_inc(cnt_q);
        out_ovf_d   = ovf_q | carry;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum_ext[ACC_W-1:0];
        cnt_d = sat_inc(cnt_q);
        ovf_d = ovf_q | carry;
      end
    end

    case (state_q)
      S_ACC: begin
        if (accept && in_last) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (prod_vld && prod_last) state_d = S_OUT;
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase

    // in_ready is registered so it stays low through reset and rises on
    // the first edge after release.
    in_ready_d = (state_d == S_ACC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACC;
      in_ready_q  <= 1'b0;
      tag_vld_q   <= '0;
      tag_last_q  <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_len_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      tag_vld_q   <= tag_vld_d;
      tag_last_q  <= tag_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_len_q   <= out_len_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_mult_dot_acc.sv
// Testbench for mult_dot_acc. A behavioural LAT-stage multiplier without reset
// stands in for mult_LP_V3. Idle-cycle operands are driven with junk values,
// so unmasked products would corrupt the sums.
module tb_mult_dot_acc;
  localparam int W     = 8;
  localparam int LAT   = 10;
  localparam int G     = 4;
  localparam int CNT_W = 8;
  localparam int ACC_W = 2*W + G;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_last;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_len;
  logic             out_ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mult_dot_acc #(.W(W), .LAT(LAT), .G(G), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_len(out_len), .out_ovf(out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: LAT register stages, no reset.
  logic [2*W-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= (2*W)'(mul_a) * (2*W)'(mul_b);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_p = mpipe[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge. Returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic last, output int acc_cyc);
    int guard;
    guard = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0; in_last = 1'b0;
    in_a = 8'hA5; in_b = 8'h5A;
  endtask

  // Waits for out_valid, then checks the result. With hs set, out_ready is
  // expected high, and the post-handshake state is checked too.
  task automatic get_result(input string name, input logic [ACC_W-1:0] exp_sum,
                            input logic [CNT_W-1:0] exp_len, input logic exp_ovf,
                            input int last_cyc, input bit chk_lat, input bit hs,
                            output int vcyc);
    int guard;
    guard = 0;
    vcyc = -1;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL %s_timeout: out_valid stayed 0, expected 1", name);
      return;
    end
    vcyc = cyc;
    check({name, "_sum"}, 32'(out_sum), 32'(exp_sum));
    check({name, "_len"}, 32'(out_len), 32'(exp_len));
    check({name, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    check({name, "_inrdy_busy"}, 32'(in_ready), 32'd0);
    if (chk_lat) check({name, "_lat"}, 32'(vcyc - last_cyc), 32'(LAT));
    if (hs) begin
      @(negedge clk);
      check({name, "_vld_clr"}, 32'(out_valid), 32'd0);
      check({name, "_inrdy_after"}, 32'(in_ready), 32'd1);
    end
  endtask

  typedef struct {
    string            name;
    int               n;
    logic [16:0][7:0] a;
    logic [16:0][7:0] b;
    bit               gap;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] len;
    logic             ovf;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int c, c1, c2, v1, vtmp;
    bit bad;
    logic [ACC_W-1:0] held_sum;

    // Vector table: inputs and hand-computed results.
    vecs[0].name = "four"; vecs[0].n = 4; vecs[0].gap = 0;
    vecs[0].a = '0; vecs[0].b = '0;
    vecs[0].a[0] = 3;   vecs[0].b[0] = 5;
    vecs[0].a[1] = 7;   vecs[0].b[1] = 2;
    vecs[0].a[2] = 255; vecs[0].b[2] = 255;
    vecs[0].a[3] = 1;   vecs[0].b[3] = 1;
    vecs[0].sum = 20'd65055; vecs[0].len = 8'd4; vecs[0].ovf = 1'b0;

    vecs[1].name = "wrap17"; vecs[1].n = 17; vecs[1].gap = 0;
    for (int i = 0; i < 17; i++) begin
      vecs[1].a[i] = 255; vecs[1].b[i] = 255;
    end
    vecs[1].sum = 20'd56849; vecs[1].len = 8'd17; vecs[1].ovf = 1'b1;

    vecs[2].name = "after_wrap"; vecs[2].n = 1; vecs[2].gap = 0;
    vecs[2].a = '0; vecs[2].b = '0;
    vecs[2].a[0] = 2; vecs[2].b[0] = 3;
    vecs[2].sum = 20'd6; vecs[2].len = 8'd1; vecs[2].ovf = 1'b0;

    vecs[3].name = "gapped"; vecs[3].n = 2; vecs[3].gap = 1;
    vecs[3].a = '0; vecs[3].b = '0;
    vecs[3].a[0] = 1; vecs[3].b[0] = 2;
    vecs[3].a[1] = 3; vecs[3].b[1] = 4;
    vecs[3].sum = 20'd14; vecs[3].len = 8'd2; vecs[3].ovf = 1'b0;

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_a = 8'hA5; in_b = 8'h5A;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_len", 32'(out_len), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);

    // Table-driven vectors, consumer always ready.
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        send(vecs[v].a[k], vecs[v].b[k], (k == vecs[v].n - 1), c);
        if (vecs[v].gap) @(negedge clk);
      end
      get_result(vecs[v].name, vecs[v].sum, vecs[v].len, vecs[v].ovf, c,
                 !vecs[v].gap, 1'b1, vtmp);
    end

    // Single pair under backpressure: outputs held, input blocked.
    out_ready = 1'b0;
    send(8'd12, 8'd10, 1'b1, c);
    get_result("bp", 20'd120, 8'd1, 1'b0, c, 1'b1, 1'b0, vtmp);
    held_sum = out_sum;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== held_sum ||
          out_len !== 8'd1 || out_ovf !== 1'b0) bad = 1;
    end
    check("bp_stable", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_vld_clr", 32'(out_valid), 32'd0);
    check("bp_inrdy_after", 32'(in_ready), 32'd1);

    // Reset in the middle of a vector; products still in the multiplier.
    send(8'd9, 8'd9, 1'b0, c);
    send(8'd9, 8'd9, 1'b0, c);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1;
    end
    check("midrst_no_spurious", 32'(bad), 32'd0);
    send(8'd2, 8'd2, 1'b1, c);
    get_result("postrst", 20'd4, 8'd1, 1'b0, c, 1'b1, 1'b1, vtmp);

    // Two single-element vectors back to back, source holds valid.
    fork
      begin
        send(8'd1, 8'd1, 1'b1, c1);
        send(8'd2, 8'd2, 1'b1, c2);
      end
      begin
        get_result("b2b_first", 20'd1, 8'd1, 1'b0, 0, 1'b0, 1'b1, v1);
      end
    join
    check("b2b_first_lat", 32'(v1 - c1), 32'(LAT));
    check("b2b_second_accept", 32'(c2 - c1), 32'(LAT + 2));
    get_result("b2b_second", 20'd4, 8'd1, 1'b0, c2, 1'b1, 1'b1, vtmp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
